// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: oversampled BCLK/LRCK/DAT capture, stereo pair assembly and a valid/ready FIFO.
// Optional peak meters are compiled in when AUDIO_RX_PEAK_EN is defined.
module audio_adc_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  adc_bclk,
    input  logic                  adc_lrck,
    input  logic                  adc_dat,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    input  logic                  clr_flags,
    output logic                  overflow,
    output logic                  frame_err
`ifdef AUDIO_RX_PEAK_EN
    ,
    output logic [DATA_WIDTH-2:0] peak_left,
    output logic [DATA_WIDTH-2:0] peak_right
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // Two-stage synchronisers for {dat, lrck, bclk}
    logic [2:0] pin_in;
    logic [2:0] sync_out;
    assign pin_in = {adc_dat, adc_lrck, adc_bclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= pin_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_out[gi] = s2_reg;
        end
    endgenerate

    // Registered rise pulse; lrck/dat are delayed alongside so they line up with it
    logic bclk_prev_reg, e_reg, lrck_d_reg, dat_d_reg;
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_prev_reg <= 1'b0;
            e_reg         <= 1'b0;
            lrck_d_reg    <= 1'b0;
            dat_d_reg     <= 1'b0;
        end else begin
            bclk_prev_reg <= sync_out[0];
            e_reg         <= sync_out[0] & ~bclk_prev_reg;
            lrck_d_reg    <= sync_out[1];
            dat_d_reg     <= sync_out[2];
        end
    end

    logic [1:0]            state_reg;
    logic                  primed_reg;
    logic                  lrck_prev_reg;
    logic                  chan_reg;
    logic                  left_ok_reg;
    logic [CW-1:0]         cnt_reg;
    logic [DATA_WIDTH-2:0] shift_reg;
    logic [DATA_WIDTH-1:0] left_word_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  lrck_chg, word_done, push, ferr_set;

    // lrck_prev is meaningless until one edge has been seen after reset
    assign lrck_chg   = primed_reg && (lrck_d_reg != lrck_prev_reg);
    assign shift_next = {shift_reg, dat_d_reg};
    assign word_done  = e_reg && (state_reg == ST_SHIFT) && !lrck_chg
                        && (cnt_reg == CW'(DATA_WIDTH - 1));
    assign push       = word_done && chan_reg && left_ok_reg;
    assign ferr_set   = e_reg && (state_reg == ST_SHIFT) && lrck_chg;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg     <= ST_IDLE;
            primed_reg    <= 1'b0;
            lrck_prev_reg <= 1'b0;
            chan_reg      <= 1'b0;
            left_ok_reg   <= 1'b0;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            left_word_reg <= '0;
        end else if (e_reg) begin
            primed_reg    <= 1'b1;
            lrck_prev_reg <= lrck_d_reg;
            if (lrck_chg) begin
                // New slot: this edge is the one-bit delay slot
                state_reg <= ST_SKIP;
                chan_reg  <= lrck_d_reg;
                cnt_reg   <= '0;
                if (!lrck_d_reg || state_reg == ST_SHIFT || state_reg == ST_SKIP)
                    left_ok_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_SKIP: begin
                        shift_reg <= shift_next[DATA_WIDTH-2:0];
                        cnt_reg   <= CW'(1);
                        state_reg <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        shift_reg <= shift_next[DATA_WIDTH-2:0];
                        cnt_reg   <= cnt_reg + CW'(1);
                        if (word_done) begin
                            state_reg <= ST_WAIT;
                            if (!chan_reg) begin
                                left_word_reg <= shift_next;
                                left_ok_reg   <= 1'b1;
                            end else begin
                                left_ok_reg   <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pair FIFO: write data comes straight from the shifter in the right LSB cycle
    logic [DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]           count_reg;
    logic                  pop, full, wr_en, ovf_set;

    assign pop     = sample_valid && sample_ready;
    assign full    = (count_reg == CNT_FULL);
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            mem_left[wr_ptr_reg]  <= left_word_reg;
            mem_right[wr_ptr_reg] <= shift_next;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    assign sample_valid = (count_reg != '0);
    // Gate the head so the outputs read zero while the FIFO is empty
    assign sample_left  = sample_valid ? mem_left[rd_ptr_reg]  : '0;
    assign sample_right = sample_valid ? mem_right[rd_ptr_reg] : '0;

    logic ovf_reg, ferr_reg;
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ovf_reg  <= 1'b0;
            ferr_reg <= 1'b0;
        end else begin
            if (ovf_set)        ovf_reg  <= 1'b1;
            else if (clr_flags) ovf_reg  <= 1'b0;
            if (ferr_set)       ferr_reg <= 1'b1;
            else if (clr_flags) ferr_reg <= 1'b0;
        end
    end
    assign overflow  = ovf_reg;
    assign frame_err = ferr_reg;

`ifdef AUDIO_RX_PEAK_EN
    function automatic logic [DATA_WIDTH-2:0] abs_sat(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] n;
        n = -s;
        if (!s[DATA_WIDTH-1])
            return s[DATA_WIDTH-2:0];
        else if (n[DATA_WIDTH-1])
            return '1;
        else
            return n[DATA_WIDTH-2:0];
    endfunction

    logic [DATA_WIDTH-2:0] peak_left_reg, peak_right_reg, abs_left, abs_right;
    assign abs_left  = abs_sat(left_word_reg);
    assign abs_right = abs_sat(shift_next);

    always_ff @(posedge clk_clk) begin
        if (reset_reset || clr_flags) begin
            peak_left_reg  <= '0;
            peak_right_reg <= '0;
        end else if (wr_en) begin
            if (abs_left > peak_left_reg)   peak_left_reg  <= abs_left;
            if (abs_right > peak_right_reg) peak_right_reg <= abs_right;
        end
    end
    assign peak_left  = peak_left_reg;
    assign peak_right = peak_right_reg;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: I2S frames are driven at clk/8, expected pairs go to a
// scoreboard queue and a negedge monitor compares every handshake against it.
module tb_audio_adc_rx;
    localparam int W    = 16;
    localparam int SLOT = 20;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic          adc_bclk, adc_lrck, adc_dat;
    logic [W-1:0]  sample_left, sample_right;
    logic          sample_valid, sample_ready, clr_flags;
    logic          overflow, frame_err;
`ifdef AUDIO_RX_PEAK_EN
    logic [W-2:0]  peak_left, peak_right;
`endif

    audio_adc_rx #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .adc_bclk     (adc_bclk),
        .adc_lrck     (adc_lrck),
        .adc_dat      (adc_dat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clr_flags    (clr_flags),
        .overflow     (overflow),
        .frame_err    (frame_err)
`ifdef AUDIO_RX_PEAK_EN
        ,
        .peak_left    (peak_left),
        .peak_right   (peak_right)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_pair;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen in this cycle pops the head on the next edge
    always @(negedge clk_clk) begin
        if (!reset_reset && sample_valid && sample_ready) begin
            pop_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got L=%h R=%h expected none", sample_left, sample_right);
            end else begin
                mon_pair = exp_q.pop_front();
                $display("pop %0d: L=%h R=%h expected L=%h R=%h", pop_count, sample_left,
                         sample_right, mon_pair[31:16], mon_pair[15:0]);
                check("pair", {sample_left, sample_right}, mon_pair);
            end
        end
    end

    task automatic set_ready(input logic v);
        @(posedge clk_clk);
        #2 sample_ready = v;
    endtask

    task automatic pulse_clr();
        @(posedge clk_clk);
        #2 clr_flags = 1'b1;
        @(posedge clk_clk);
        #2 clr_flags = 1'b0;
        @(negedge clk_clk);
    endtask

    // mode 0: plain bit; 1: check valid latency after this rise; 2: ready only in the push cycle
    task automatic send_bit(input logic l, input logic d, input int mode);
        adc_bclk = 1'b0;
        adc_lrck = l;
        adc_dat  = d;
        repeat (4) @(negedge clk_clk);
        adc_bclk = 1'b1;
        if (mode == 1) begin
            repeat (3) @(negedge clk_clk);
            check("valid_before_push", 32'(sample_valid), 0);
            @(negedge clk_clk);
            check("valid_after_push", 32'(sample_valid), 1);
        end else if (mode == 2) begin
            repeat (3) @(posedge clk_clk);
            #2 sample_ready = 1'b1;
            @(posedge clk_clk);
            #2 sample_ready = 1'b0;
            @(negedge clk_clk);
        end else begin
            repeat (4) @(negedge clk_clk);
        end
    endtask

    task automatic do_reset_mid();
        @(posedge clk_clk);
        #2 reset_reset = 1'b1;
        exp_q.delete();
        @(posedge clk_clk);
        #2 reset_reset = 1'b0;
        @(negedge clk_clk);
        check("rst_mid_valid", 32'(sample_valid), 0);
        check("rst_mid_left", 32'(sample_left), 0);
        check("rst_mid_right", 32'(sample_right), 0);
        check("rst_mid_flags", {30'd0, overflow, frame_err}, 0);
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lbits,
                              input bit expect_push, input int lsb_mode, input int rst_at);
        int   llen;
        logic d;
        llen = (lbits < W) ? lbits + 1 : SLOT;
        if (expect_push) exp_q.push_back({l, r});
        for (int i = 0; i < llen; i++) begin
            d = (i == 0) ? 1'b1 : ((i <= W) ? l[W-i] : 1'b0);
            send_bit(1'b0, d, 0);
        end
        for (int i = 0; i < SLOT; i++) begin
            if (i == rst_at) do_reset_mid();
            d = (i == 0) ? 1'b1 : ((i <= W) ? r[W-i] : 1'b0);
            send_bit(1'b1, d, (i == W) ? lsb_mode : 0);
        end
    endtask

    int base;

    initial begin
        reset_reset  = 1'b1;
        adc_bclk     = 1'b0;
        adc_lrck     = 1'b0;
        adc_dat      = 1'b0;
        sample_ready = 1'b0;
        clr_flags    = 1'b0;
        repeat (4) @(posedge clk_clk);
        #2 reset_reset = 1'b0;
        @(negedge clk_clk);
        check("reset_valid", 32'(sample_valid), 0);
        check("reset_left", 32'(sample_left), 0);
        check("reset_right", 32'(sample_right), 0);
        check("reset_overflow", 32'(overflow), 0);
        check("reset_frame_err", 32'(frame_err), 0);

        // Clean frames: the first one is not a complete pair after reset
        set_ready(1'b1);
        send_frame(16'h1234, 16'hABCD, W, 0, 0, -1);
        send_frame(16'h1234, 16'hABCD, W, 1, 1, -1);
        send_frame(16'h1234, 16'hABCD, W, 1, 1, -1);
        repeat (10) @(negedge clk_clk);
        check("clean_pops", 32'(pop_count), 2);
        check("clean_flags", {30'd0, overflow, frame_err}, 0);

        // Stalled consumer: four retained, fifth and sixth dropped
        set_ready(1'b0);
        for (int k = 1; k <= 6; k++) begin
            send_frame(16'h1100 + 16'(k), 16'h2200 + 16'(k), W, (k <= 4), 0, -1);
            check("stall_overflow", 32'(overflow), (k >= 5) ? 1 : 0);
        end
        pulse_clr();
        check("clr_overflow", 32'(overflow), 0);
        check("full_valid", 32'(sample_valid), 1);

        // Full FIFO with ready only in the push cycle
        base = pop_count;
        send_frame(16'h3333, 16'h4444, W, 1, 2, -1);
        check("same_cycle_overflow", 32'(overflow), 0);
        set_ready(1'b1);
        repeat (20) @(negedge clk_clk);
        check("same_cycle_pops", 32'(pop_count - base), 5);
        check("drained_valid", 32'(sample_valid), 0);

        // Truncated left word
        base = pop_count;
        send_frame(16'h5555, 16'h6666, 10, 0, 0, -1);
        check("trunc_frame_err", 32'(frame_err), 1);
        send_frame(16'h7777, 16'h8888, W, 1, 0, -1);
        repeat (10) @(negedge clk_clk);
        check("trunc_pops", 32'(pop_count - base), 1);

        // Reset mid right word with two pairs queued
        set_ready(1'b0);
        send_frame(16'h0A0A, 16'h0B0B, W, 1, 0, -1);
        send_frame(16'h0C0C, 16'h0D0D, W, 1, 0, -1);
        send_frame(16'h0E0E, 16'h0F0F, W, 0, 0, 8);
        check("post_rst_valid", 32'(sample_valid), 0);
        base = pop_count;
        set_ready(1'b1);
        send_frame(16'h1357, 16'h2468, W, 1, 0, -1);
        repeat (10) @(negedge clk_clk);
        check("post_rst_pops", 32'(pop_count - base), 1);

`ifdef AUDIO_RX_PEAK_EN
        pulse_clr();
        send_frame(16'h8000, 16'h0002, W, 1, 0, -1);
        send_frame(16'h0100, 16'hFFFE, W, 1, 0, -1);
        repeat (10) @(negedge clk_clk);
        check("peak_left", 32'(peak_left), 32'h7FFF);
        check("peak_right", 32'(peak_right), 32'h0002);
        pulse_clr();
        check("peak_left_clr", 32'(peak_left), 0);
        check("peak_right_clr", 32'(peak_right), 0);
`endif

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
